// File: rtl/uart_tx_scheduler_if.sv
// uart_tx_scheduler_if: requester handshake plus UART register-bus signals
// shared between the scheduler (master modport) and its environment (slave modport).
interface uart_tx_scheduler_if #(
  parameter int N_REQ = 4
);
  localparam int GID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  // Requester side
  logic [N_REQ-1:0]   req_valid;
  logic [8*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]   req_ready;

  // UART register bus
  logic               m_valid;
  logic               m_ready;
  logic [31:0]        m_address;
  logic [3:0]         m_wstrobe;
  logic [31:0]        m_wdata;
  logic [31:0]        m_rdata;

  // Status
  logic               busy;
  logic [GID_W-1:0]   grant_id;
  logic               timeout;

  modport master (
    input  req_valid, req_data, m_ready, m_rdata,
    output req_ready, m_valid, m_address, m_wstrobe, m_wdata,
           busy, grant_id, timeout
  );

  modport slave (
    output req_valid, req_data, m_ready, m_rdata,
    input  req_ready, m_valid, m_address, m_wstrobe, m_wdata,
           busy, grant_id, timeout
  );
endinterface

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: shares one UART between N_REQ byte requesters.
// After reset it writes the baud divisor once, then serves requesters in
// round-robin order: DATA write, STATUS poll until tx_event is set, then a
// write-1-to-clear of that flag before the next byte.
// Optional feature macro: UART_SCHED_TIMEOUT_EN adds TIMEOUT_POLLS and a
// sticky poll-timeout flag; without it POLL waits forever and timeout is 0.
module uart_tx_scheduler #(
  parameter int          N_REQ          = 4,
  parameter logic [31:0] BASE_ADDRESS   = 32'h0,
  parameter int          CONTROL_INDEX  = 0,
  parameter int          STATUS_INDEX   = 1,
  parameter int          DIVISION_INDEX = 2,
  parameter int          DATA_INDEX     = 3,
  parameter int          TX_EVENT_BIT   = 0,
  parameter logic [31:0] DIVISION       = 32'd0
`ifdef UART_SCHED_TIMEOUT_EN
  ,
  parameter int          TIMEOUT_POLLS  = 1024
`endif
) (
  input  logic                 clk,
  input  logic                 reset,
  uart_tx_scheduler_if.master  bus
);

  localparam int GID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  localparam logic [31:0] STATUS_ADDR   = BASE_ADDRESS + 32'(4 * STATUS_INDEX);
  localparam logic [31:0] DIVISION_ADDR = BASE_ADDRESS + 32'(4 * DIVISION_INDEX);
  localparam logic [31:0] DATA_ADDR     = BASE_ADDRESS + 32'(4 * DATA_INDEX);
  localparam logic [31:0] CLEAR_WDATA   = 32'd1 << TX_EVENT_BIT;
  // CONTROL is never written (interrupt setup belongs to software); the
  // address is kept only so the register map reads completely here.
  localparam logic [31:0] unused_control_addr = BASE_ADDRESS + 32'(4 * CONTROL_INDEX);

`ifdef UART_SCHED_TIMEOUT_EN
  localparam int           TO_W      = (TIMEOUT_POLLS > 1) ? $clog2(TIMEOUT_POLLS) : 1;
  localparam logic [TO_W-1:0] POLL_LAST = TO_W'(TIMEOUT_POLLS - 1);
`endif

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_IDLE  = 3'd1,
    ST_SEND  = 3'd2,
    ST_POLL  = 3'd3,
    ST_CLEAR = 3'd4
  } state_t;

  state_t            state_r;
  logic [GID_W-1:0]  rr_ptr_r;
  logic [GID_W-1:0]  grant_id_r;
  logic              busy_r;
  logic              m_valid_r;
  logic [31:0]       m_address_r;
  logic [3:0]        m_wstrobe_r;
  logic [31:0]       m_wdata_r;
`ifdef UART_SCHED_TIMEOUT_EN
  logic              timeout_r;
  logic [TO_W-1:0]   poll_cnt_r;
`endif

  logic              any_req_s;
  logic [GID_W-1:0]  grant_idx_s;
  logic [GID_W-1:0]  next_ptr_s;
  logic [7:0]        grant_byte_s;
  logic [N_REQ-1:0]  req_ready_s;
  logic              flag_s;
  logic              xfer_done_s;
  logic              hit_s;
  logic              sel_s;
  int                dist_s;
  int                best_d_s;
  logic              unused_rdata_s;

  assign flag_s         = bus.m_rdata[TX_EVENT_BIT];
  assign xfer_done_s    = m_valid_r & bus.m_ready;
  assign unused_rdata_s = ^bus.m_rdata;

  // Round-robin pick: the valid requester closest at or after rr_ptr (with wrap)
  always_comb begin
    any_req_s   = 1'b0;
    grant_idx_s = '0;
    best_d_s    = N_REQ;
    dist_s      = 0;
    hit_s       = 1'b0;
    for (int j = 0; j < N_REQ; j++) begin
      dist_s      = (j + N_REQ - int'(rr_ptr_r)) % N_REQ;
      hit_s       = bus.req_valid[j] & (dist_s < best_d_s);
      best_d_s    = hit_s ? dist_s : best_d_s;
      grant_idx_s = hit_s ? GID_W'(j) : grant_idx_s;
      any_req_s   = any_req_s | hit_s;
    end
  end

  // Grant pulse and granted byte; req_ready follows req_valid in IDLE so a
  // requester that withdraws before the grant edge is never acknowledged
  always_comb begin
    grant_byte_s = 8'h00;
    req_ready_s  = '0;
    sel_s        = 1'b0;
    for (int j = 0; j < N_REQ; j++) begin
      sel_s          = (GID_W'(j) == grant_idx_s);
      grant_byte_s   = sel_s ? bus.req_data[8*j +: 8] : grant_byte_s;
      req_ready_s[j] = sel_s & any_req_s & (state_r == ST_IDLE);
    end
    if (grant_idx_s == GID_W'(N_REQ - 1)) begin
      next_ptr_s = '0;
    end else begin
      next_ptr_s = grant_idx_s + GID_W'(1);
    end
  end

  // Sequencer FSM: owns every bus output as a register so they stay stable while m_valid is high
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_INIT;
      rr_ptr_r    <= '0;
      grant_id_r  <= '0;
      busy_r      <= 1'b1;
      m_valid_r   <= 1'b0;
      m_address_r <= 32'h0;
      m_wstrobe_r <= 4'h0;
      m_wdata_r   <= 32'h0;
`ifdef UART_SCHED_TIMEOUT_EN
      timeout_r   <= 1'b0;
      poll_cnt_r  <= '0;
`endif
    end else begin
      case (state_r)
        ST_INIT: begin
          if (!m_valid_r) begin
            m_valid_r   <= 1'b1;
            m_address_r <= DIVISION_ADDR;
            m_wstrobe_r <= 4'hF;
            m_wdata_r   <= DIVISION;
          end else if (bus.m_ready) begin
            m_valid_r   <= 1'b0;
            m_address_r <= 32'h0;
            m_wstrobe_r <= 4'h0;
            m_wdata_r   <= 32'h0;
            busy_r      <= 1'b0;
            state_r     <= ST_IDLE;
          end
        end
        ST_IDLE: begin
          if (any_req_s) begin
            grant_id_r  <= grant_idx_s;
            rr_ptr_r    <= next_ptr_s;
            busy_r      <= 1'b1;
            m_valid_r   <= 1'b1;
            m_address_r <= DATA_ADDR;
            m_wstrobe_r <= 4'h1;
            m_wdata_r   <= {24'h0, grant_byte_s};
            state_r     <= ST_SEND;
          end
        end
        ST_SEND: begin
          // Chain straight into the first STATUS read without a bubble
          if (xfer_done_s) begin
            m_address_r <= STATUS_ADDR;
            m_wstrobe_r <= 4'h0;
            m_wdata_r   <= 32'h0;
            state_r     <= ST_POLL;
`ifdef UART_SCHED_TIMEOUT_EN
            poll_cnt_r  <= '0;
`endif
          end
        end
        ST_POLL: begin
          if (!m_valid_r) begin
            m_valid_r <= 1'b1;
          end else if (bus.m_ready) begin
            if (flag_s) begin
              m_wstrobe_r <= 4'hF;
              m_wdata_r   <= CLEAR_WDATA;
              state_r     <= ST_CLEAR;
            end
`ifdef UART_SCHED_TIMEOUT_EN
            else if (poll_cnt_r == POLL_LAST) begin
              timeout_r   <= 1'b1;
              m_wstrobe_r <= 4'hF;
              m_wdata_r   <= CLEAR_WDATA;
              state_r     <= ST_CLEAR;
            end else begin
              poll_cnt_r  <= poll_cnt_r + TO_W'(1);
              m_valid_r   <= 1'b0;
            end
`else
            else begin
              m_valid_r   <= 1'b0;
            end
`endif
          end
        end
        ST_CLEAR: begin
          if (xfer_done_s) begin
            m_valid_r   <= 1'b0;
            m_address_r <= 32'h0;
            m_wstrobe_r <= 4'h0;
            m_wdata_r   <= 32'h0;
            busy_r      <= 1'b0;
            state_r     <= ST_IDLE;
          end
        end
        default: begin
          state_r   <= ST_INIT;
          busy_r    <= 1'b1;
          m_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready = req_ready_s;
  assign bus.m_valid   = m_valid_r;
  assign bus.m_address = m_address_r;
  assign bus.m_wstrobe = m_wstrobe_r;
  assign bus.m_wdata   = m_wdata_r;
  assign bus.busy      = busy_r;
  assign bus.grant_id  = grant_id_r;
`ifdef UART_SCHED_TIMEOUT_EN
  assign bus.timeout   = timeout_r;
`else
  assign bus.timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb_uart_tx_scheduler: directed bench for uart_tx_scheduler with a small
// UART slave model that logs completed transfers and req_ready pulses.
module tb_uart_tx_scheduler;
  localparam int          N      = 4;
  localparam logic [31:0] BASE   = 32'h4000_1000;
  localparam logic [31:0] DIVV   = 32'd433;
  localparam logic [31:0] A_STAT = 32'h4000_1004;
  localparam logic [31:0] A_DIV  = 32'h4000_1008;
  localparam logic [31:0] A_DATA = 32'h4000_100C;

  typedef struct {
    int          cyc;
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [31:0] data;
  } xfer_t;

  typedef struct {
    int          cyc;
    logic [N-1:0] rdy;
  } grant_t;

  logic clk = 1'b0;
  logic reset;

  xfer_t  xlog[$];
  grant_t glog[$];
  bit     status_q[$];
  bit     default_status;
  int     ready_wait;
  int     wait_cnt;
  int     cyc;
  int     stab_err;
  bit     pend;
  logic [31:0] h_addr;
  logic [31:0] h_data;
  logic [3:0]  h_strb;
  int     n_tests;
  int     n_fail;

  always #5 clk = ~clk;

  uart_tx_scheduler_if #(.N_REQ(N)) u_if ();

  uart_tx_scheduler #(
    .N_REQ(N),
    .BASE_ADDRESS(BASE),
    .DIVISION(DIVV)
`ifdef UART_SCHED_TIMEOUT_EN
    ,
    .TIMEOUT_POLLS(8)
`endif
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(u_if)
  );

  // Slave model: drives m_ready/m_rdata after each rising edge, logs on the falling edge
  initial begin
    u_if.m_ready = 1'b0;
    u_if.m_rdata = 32'h0;
    wait_cnt = 0;
    cyc      = 0;
    stab_err = 0;
    pend     = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (u_if.m_valid) begin
        if (wait_cnt < ready_wait) begin
          u_if.m_ready = 1'b0;
          wait_cnt++;
        end else begin
          u_if.m_ready = 1'b1;
        end
      end else begin
        u_if.m_ready = (ready_wait == 0);
        wait_cnt = 0;
      end
      u_if.m_rdata = {31'h7FFF_FFFF, (status_q.size() > 0) ? status_q[0] : default_status};
      @(negedge clk);
      cyc++;
      if (reset) begin
        pend = 1'b0;
      end else if (u_if.m_valid) begin
        if (pend && (u_if.m_address !== h_addr || u_if.m_wdata !== h_data || u_if.m_wstrobe !== h_strb))
          stab_err++;
        if (u_if.m_ready) begin
          xlog.push_back('{cyc, u_if.m_address, u_if.m_wstrobe, u_if.m_wdata});
          if (u_if.m_wstrobe == 4'h0 && status_q.size() > 0) void'(status_q.pop_front());
          wait_cnt = 0;
          pend = 1'b0;
        end else begin
          pend   = 1'b1;
          h_addr = u_if.m_address;
          h_data = u_if.m_wdata;
          h_strb = u_if.m_wstrobe;
        end
      end else begin
        if (pend) stab_err++;
        pend = 1'b0;
      end
      if (u_if.req_ready !== '0) glog.push_back('{cyc, u_if.req_ready});
    end
  end

  task automatic wait_xfers(input int k, input int budget);
    int n = 0;
    while (xlog.size() < k && n < budget) begin
      @(posedge clk); #1; n++;
    end
  endtask

  task automatic wait_grants(input int k, input int budget);
    int n = 0;
    while (glog.size() < k && n < budget) begin
      @(posedge clk); #1; n++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if ({u_if.m_valid, u_if.busy, u_if.timeout, u_if.grant_id, u_if.req_ready, u_if.m_wstrobe}
        !== {1'b0, 1'b1, 1'b0, 2'd0, 4'd0, 4'd0}) begin
      n_fail++;
      $display("FAIL reset_flags: got v=%b busy=%b to=%b gid=%0d rdy=%b strb=%h want v=0 busy=1 to=0 gid=0 rdy=0 strb=0",
               u_if.m_valid, u_if.busy, u_if.timeout, u_if.grant_id, u_if.req_ready, u_if.m_wstrobe);
    end
    n_tests++;
    if (u_if.m_address !== 32'h0 || u_if.m_wdata !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_bus: got addr=%h wdata=%h want 0/0", u_if.m_address, u_if.m_wdata);
    end
  endtask

  task automatic test_init();
    xlog.delete();
    reset = 1'b0;
    @(posedge clk); #1;
    n_tests++;
    if (u_if.m_valid !== 1'b1 || u_if.m_address !== A_DIV) begin
      n_fail++;
      $display("FAIL init_first_cycle: got v=%b addr=%h want v=1 addr=%h", u_if.m_valid, u_if.m_address, A_DIV);
    end
    wait_xfers(1, 20);
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (xlog.size() != 1) begin
      n_fail++;
      $display("FAIL init_count: got %0d transfers want 1", xlog.size());
    end else begin
      n_tests++;
      if (xlog[0].addr !== A_DIV || xlog[0].strb !== 4'hF || xlog[0].data !== DIVV) begin
        n_fail++;
        $display("FAIL init_write: got %h/%h/%0d want %h/f/433", xlog[0].addr, xlog[0].strb, xlog[0].data, A_DIV);
      end
    end
    n_tests++;
    if (u_if.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL init_busy: got %b want 0", u_if.busy);
    end
  endtask

  task automatic test_round_robin();
    int nd = 0;
    logic [N-1:0] exp_rdy;
    logic [7:0]   exp_b;
    xlog.delete(); glog.delete();
    default_status = 1'b1;
    u_if.req_data  = {8'h13, 8'h12, 8'h11, 8'h10};
    u_if.req_valid = 4'hF;
    wait_grants(8, 100);
    u_if.req_valid = 4'h0;
    repeat (6) @(posedge clk);
    #1;
    n_tests++;
    if (glog.size() != 8) begin
      n_fail++;
      $display("FAIL rr_grant_count: got %0d want 8", glog.size());
    end
    for (int k = 0; k < glog.size(); k++) begin
      exp_rdy = 4'b0001 << (k % 4);
      n_tests++;
      if (glog[k].rdy !== exp_rdy) begin
        n_fail++;
        $display("FAIL rr_grant_%0d: got %b want %b", k, glog[k].rdy, exp_rdy);
      end
      if (k > 0) begin
        n_tests++;
        if (glog[k].cyc - glog[k-1].cyc != 4) begin
          n_fail++;
          $display("FAIL rr_spacing_%0d: got %0d cycles want 4", k, glog[k].cyc - glog[k-1].cyc);
        end
      end
    end
    foreach (xlog[j]) begin
      if (xlog[j].addr == A_DATA) begin
        exp_b = 8'h10 + 8'(nd % 4);
        n_tests++;
        if (xlog[j].data !== {24'h0, exp_b} || xlog[j].strb !== 4'h1) begin
          n_fail++;
          $display("FAIL rr_data_%0d: got %h/%h want %h/1", nd, xlog[j].data, xlog[j].strb, exp_b);
        end
        nd++;
      end
    end
    n_tests++;
    if (nd != 8) begin
      n_fail++;
      $display("FAIL rr_data_count: got %0d want 8", nd);
    end
  endtask

  task automatic test_single();
    xlog.delete(); glog.delete();
    status_q.push_back(1'b0);
    status_q.push_back(1'b0);
    status_q.push_back(1'b1);
    u_if.req_data  = {8'hEE, 8'h5A, 8'hEE, 8'hEE};
    u_if.req_valid = 4'b0100;
    wait_grants(1, 20);
    u_if.req_valid = 4'b0000;
    u_if.req_data  = {8'hA5, 8'hA5, 8'hA5, 8'hA5};
    wait_xfers(5, 60);
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (glog.size() != 1 || xlog.size() != 5) begin
      n_fail++;
      $display("FAIL single_counts: got grants=%0d xfers=%0d want 1/5", glog.size(), xlog.size());
    end else begin
      n_tests++;
      if (glog[0].rdy !== 4'b0100) begin
        n_fail++;
        $display("FAIL single_ready: got %b want 0100", glog[0].rdy);
      end
      n_tests++;
      if (xlog[0].addr !== A_DATA || xlog[0].strb !== 4'h1 || xlog[0].data !== 32'h5A) begin
        n_fail++;
        $display("FAIL single_data: got %h/%h/%h want %h/1/5a", xlog[0].addr, xlog[0].strb, xlog[0].data, A_DATA);
      end
      n_tests++;
      if (xlog[0].cyc - glog[0].cyc != 1) begin
        n_fail++;
        $display("FAIL single_latency: got %0d want 1", xlog[0].cyc - glog[0].cyc);
      end
      for (int k = 1; k <= 3; k++) begin
        n_tests++;
        if (xlog[k].addr !== A_STAT || xlog[k].strb !== 4'h0) begin
          n_fail++;
          $display("FAIL single_poll_%0d: got %h/%h want %h/0", k, xlog[k].addr, xlog[k].strb, A_STAT);
        end
        if (k > 1) begin
          n_tests++;
          if (xlog[k].cyc - xlog[k-1].cyc != 2) begin
            n_fail++;
            $display("FAIL single_poll_gap_%0d: got %0d want 2", k, xlog[k].cyc - xlog[k-1].cyc);
          end
        end
      end
      n_tests++;
      if (xlog[4].addr !== A_STAT || xlog[4].strb !== 4'hF || xlog[4].data !== 32'h1) begin
        n_fail++;
        $display("FAIL single_clear: got %h/%h/%h want %h/f/1", xlog[4].addr, xlog[4].strb, xlog[4].data, A_STAT);
      end
    end
    n_tests++;
    if (u_if.grant_id !== 2'd2 || u_if.busy !== 1'b0 || u_if.timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL single_status: got gid=%0d busy=%b to=%b want 2/0/0", u_if.grant_id, u_if.busy, u_if.timeout);
    end
  endtask

  task automatic test_stall();
    int base_err = stab_err;
    int nd = 0;
    xlog.delete(); glog.delete();
    ready_wait     = 5;
    default_status = 1'b1;
    u_if.req_data  = {8'h00, 8'h00, 8'hC3, 8'h00};
    u_if.req_valid = 4'b0010;
    wait_grants(1, 20);
    u_if.req_valid = 4'b0000;
    wait_xfers(3, 100);
    ready_wait = 0;
    repeat (3) @(posedge clk);
    #1;
    foreach (xlog[j]) if (xlog[j].addr == A_DATA) nd++;
    n_tests++;
    if (nd != 1 || xlog.size() != 3 || glog.size() != 1) begin
      n_fail++;
      $display("FAIL stall_counts: got data=%0d xfers=%0d grants=%0d want 1/3/1", nd, xlog.size(), glog.size());
    end else begin
      n_tests++;
      if (xlog[0].data !== 32'hC3 || xlog[0].strb !== 4'h1) begin
        n_fail++;
        $display("FAIL stall_data: got %h/%h want c3/1", xlog[0].data, xlog[0].strb);
      end
      n_tests++;
      if (xlog[0].cyc - glog[0].cyc != 6) begin
        n_fail++;
        $display("FAIL stall_latency: got %0d want 6", xlog[0].cyc - glog[0].cyc);
      end
    end
    n_tests++;
    if (stab_err != base_err) begin
      n_fail++;
      $display("FAIL stall_stability: got %0d unstable cycles want 0", stab_err - base_err);
    end
  endtask

  task automatic test_reset_mid_poll();
    int nd = 0;
    xlog.delete(); glog.delete();
    ready_wait     = 0;
    default_status = 1'b0;
    u_if.req_data  = {8'h00, 8'h00, 8'h77, 8'h00};
    u_if.req_valid = 4'b0010;
    wait_grants(1, 20);
    u_if.req_valid = 4'b0000;
    wait_xfers(3, 40);
    reset = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if (u_if.m_valid !== 1'b0 || u_if.busy !== 1'b1 || u_if.grant_id !== 2'd0) begin
      n_fail++;
      $display("FAIL rst_poll_state: got v=%b busy=%b gid=%0d want 0/1/0", u_if.m_valid, u_if.busy, u_if.grant_id);
    end
    xlog.delete(); glog.delete();
    reset = 1'b0;
    default_status = 1'b1;
    wait_xfers(1, 20);
    u_if.req_data  = {8'h99, 8'h00, 8'h00, 8'h66};
    u_if.req_valid = 4'b1001;
    wait_grants(1, 20);
    u_if.req_valid = 4'b0000;
    wait_xfers(4, 40);
    repeat (3) @(posedge clk);
    #1;
    foreach (xlog[j]) if (xlog[j].addr == A_DATA) nd++;
    n_tests++;
    if (xlog.size() != 4 || glog.size() != 1 || nd != 1) begin
      n_fail++;
      $display("FAIL rst_poll_counts: got xfers=%0d grants=%0d data=%0d want 4/1/1", xlog.size(), glog.size(), nd);
    end else begin
      n_tests++;
      if (xlog[0].addr !== A_DIV || xlog[0].strb !== 4'hF || xlog[0].data !== DIVV) begin
        n_fail++;
        $display("FAIL rst_poll_div: got %h/%h/%0d want %h/f/433", xlog[0].addr, xlog[0].strb, xlog[0].data, A_DIV);
      end
      n_tests++;
      if (glog[0].rdy !== 4'b0001) begin
        n_fail++;
        $display("FAIL rst_poll_rrptr: got %b want 0001", glog[0].rdy);
      end
      n_tests++;
      if (xlog[1].addr !== A_DATA || xlog[1].data !== 32'h66) begin
        n_fail++;
        $display("FAIL rst_poll_data: got %h/%h want %h/66", xlog[1].addr, xlog[1].data, A_DATA);
      end
    end
  endtask

`ifdef UART_SCHED_TIMEOUT_EN
  task automatic test_timeout();
    int nr = 0;
    xlog.delete(); glog.delete();
    ready_wait     = 0;
    default_status = 1'b0;
    u_if.req_data  = {8'h00, 8'h42, 8'h00, 8'h00};
    u_if.req_valid = 4'b0100;
    wait_grants(1, 20);
    u_if.req_valid = 4'b0000;
    wait_xfers(10, 80);
    repeat (3) @(posedge clk);
    #1;
    foreach (xlog[j]) if (xlog[j].strb == 4'h0) nr++;
    n_tests++;
    if (nr != 8 || xlog.size() != 10) begin
      n_fail++;
      $display("FAIL timeout_reads: got reads=%0d xfers=%0d want 8/10", nr, xlog.size());
    end else begin
      n_tests++;
      if (xlog[9].addr !== A_STAT || xlog[9].strb !== 4'hF || xlog[9].data !== 32'h1) begin
        n_fail++;
        $display("FAIL timeout_clear: got %h/%h/%h want %h/f/1", xlog[9].addr, xlog[9].strb, xlog[9].data, A_STAT);
      end
    end
    n_tests++;
    if (u_if.timeout !== 1'b1 || u_if.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_flag: got to=%b busy=%b want 1/0", u_if.timeout, u_if.busy);
    end
    default_status = 1'b1;
    u_if.req_valid = 4'b0001;
    wait_grants(2, 20);
    u_if.req_valid = 4'b0000;
    repeat (8) @(posedge clk);
    #1;
    n_tests++;
    if (u_if.timeout !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_sticky: got %b want 1", u_if.timeout);
    end
  endtask
`endif

  initial begin
    n_tests        = 0;
    n_fail         = 0;
    reset          = 1'b1;
    ready_wait     = 0;
    default_status = 1'b1;
    u_if.req_valid = '0;
    u_if.req_data  = '0;
    test_reset();
    test_init();
    test_round_robin();
    test_single();
    test_stall();
    test_reset_mid_poll();
`ifdef UART_SCHED_TIMEOUT_EN
    test_timeout();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
